dmem_responder: RTL

//   Memory-side responder for the core's load/store port: the data RAM the core's load-store stage talks to.

---
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: byte/half/word stores with lane enables,
// sign/zero-extended loads, registered response with range/alignment error flag.
// Optional build macro DMEM_WAIT_STATES_EN adds an IDLE/BUSY/RESP wait-state sequencer.
module dmem_responder #(
    parameter int               XLEN        = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0]  BASE_ADDR   = 32'h0000_1000,
    parameter int               WAIT_CYCLES = 2,
    parameter string            INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      n_bytes,
    input  logic            l_unsigned,
    output logic            ready,
    output logic            rvalid,
    output logic [XLEN-1:0] rdata,
    output logic            addr_err
);
    localparam int              NB   = XLEN / 8;
    localparam int              AW   = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN = XLEN'(4 * DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("dmem_responder: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    // Access currently being executed against the RAM (commit/sample point)
    logic            x_go;
    logic            x_write;
    logic            x_unsigned;
    logic [XLEN-1:0] x_addr;
    logic [XLEN-1:0] x_wdata;
    logic [1:0]      x_size;

`ifdef DMEM_WAIT_STATES_EN
    // state | meaning
    // IDLE  | ready=1, waiting for an accept; request fields captured on accept
    // BUSY  | ready=0, wait-state down-counter running; RAM access when cnt==0
    // RESP  | ready=0, rvalid=1 for one cycle
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            c_write, c_unsigned;
    logic [XLEN-1:0] c_addr, c_wdata;
    logic [1:0]      c_size;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            c_write    <= write;
            c_unsigned <= l_unsigned;
            c_addr     <= addr;
            c_wdata    <= wdata;
            c_size     <= n_bytes;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        x_go      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(WAIT_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    x_go      = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign x_write    = c_write;
    assign x_unsigned = c_unsigned;
    assign x_addr     = c_addr;
    assign x_wdata    = c_wdata;
    assign x_size     = c_size;
`else
    assign ready      = 1'b1;
    assign x_go       = req;
    assign x_write    = write;
    assign x_unsigned = l_unsigned;
    assign x_addr     = addr;
    assign x_wdata    = wdata;
    assign x_size     = n_bytes;
`endif

    logic [XLEN-1:0] offset;
    logic            in_range;
    logic            misalign;
    logic            err;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wshift;
    logic [XLEN-1:0] rword;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] ld_data;

    assign offset   = x_addr - BASE_ADDR;
    assign in_range = (x_addr >= BASE_ADDR) && (offset < SPAN);
    assign misalign = (x_size == 2'd1 && x_addr[0])
                   || (x_size == 2'd2 && x_addr[1:0] != 2'b00)
                   || (x_size == 2'd3);
    assign err      = !in_range || misalign;
    assign idx      = offset[AW+1:2];
    assign lane     = x_addr[1:0];
    assign wshift   = x_wdata << {lane, 3'b000};
    assign rword    = mem[idx];
    assign rshift   = rword >> {lane, 3'b000};

    always_comb begin
        be = '1;
        case (x_size)
            2'd0:    be = NB'(4'b0001 << lane);
            2'd1:    be = NB'(4'b0011 << lane);
            default: be = '1;
        endcase
    end

    always_comb begin
        ld_data = rword;
        case (x_size)
            2'd0: ld_data = x_unsigned ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                       : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            2'd1: ld_data = x_unsigned ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                       : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            default: ld_data = rword;
        endcase
    end

    // Reset also blocks the commit so a store caught by reset leaves the RAM untouched
    always_ff @(posedge clk) begin
        if (x_go && x_write && !err && !rst) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid   <= 1'b0;
            rdata    <= '0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= x_go;
            addr_err <= x_go && err;
            rdata    <= (x_go && !x_write && !err) ? ld_data : '0;
        end
    end
endmodule
